// File: rtl/seq_pattern_checker_if.sv
// rtl/seq_pattern_checker_if.sv - configuration, control and status bundle for seq_pattern_checker
interface seq_pattern_checker_if #(
    parameter int N_IN   = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    parameter int FCNT_W = 8
);
    localparam int AW = $clog2(DEPTH);

    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [N_IN-1:0]   cfg_pattern;
    logic [N_IN-1:0]   cfg_mask;
    logic [CNT_W-1:0]  cfg_dwell;
    logic              cfg_last;
    logic              start;
    logic              abort;
    logic              restart_on_fail;
    logic [N_IN-1:0]   din;
    logic              busy;
    logic              done;
    logic              fail;
    logic [AW-1:0]     step;
    logic [AW-1:0]     fail_step;
    logic [FCNT_W-1:0] fail_count;

    modport master (
        output cfg_we, cfg_addr, cfg_pattern, cfg_mask, cfg_dwell, cfg_last,
        output start, abort, restart_on_fail, din,
        input  busy, done, fail, step, fail_step, fail_count
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_pattern, cfg_mask, cfg_dwell, cfg_last,
        input  start, abort, restart_on_fail, din,
        output busy, done, fail, step, fail_step, fail_count
    );
endinterface

// File: rtl/seq_pattern_checker.sv
// rtl/seq_pattern_checker.sv - programmable timed input-sequence checker
module seq_pattern_checker #(
    parameter int N_IN   = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    parameter int FCNT_W = 8
) (
    input logic                clk,
    input logic                reset,
    seq_pattern_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     fail_step_q, fail_step_d;
    logic [FCNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic              cfg_wr;

    logic [N_IN-1:0]   pat_q   [DEPTH];
    logic [N_IN-1:0]   mask_q  [DEPTH];
    logic [CNT_W-1:0]  dwell_q [DEPTH];
    logic              last_q  [DEPTH];

    logic [AW-1:0]     step_nx;
    logic              match;
    logic              at_end;

    assign step_nx = step_q + AW'(1);
    assign match   = ((bus.din ^ pat_q[step_q]) & mask_q[step_q]) == '0;
    assign at_end  = last_q[step_q] || (step_q == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            fail_step_q <= '0;
            fail_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pat_q[i]   <= '0;
                mask_q[i]  <= '0;
                dwell_q[i] <= '0;
                last_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            fail_step_q <= fail_step_d;
            fail_cnt_q  <= fail_cnt_d;
            if (cfg_wr) begin
                pat_q[bus.cfg_addr]   <= bus.cfg_pattern;
                mask_q[bus.cfg_addr]  <= bus.cfg_mask;
                dwell_q[bus.cfg_addr] <= bus.cfg_dwell;
                last_q[bus.cfg_addr]  <= bus.cfg_last;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        fail_step_d = fail_step_q;
        fail_cnt_d  = fail_cnt_q;
        cfg_wr      = 1'b0;

        case (state_q)
            S_RUN: begin
                // Abort beats a coincident sample: nothing from that cycle is recorded.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (match) begin
                    if (at_end) begin
                        state_d = S_PASS;
                    end else begin
                        step_d = step_nx;
                        cnt_d  = dwell_q[step_nx];
                    end
                end else begin
                    fail_step_d = step_q;
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + FCNT_W'(1);
                    end
                    if (bus.restart_on_fail) begin
                        step_d = '0;
                        cnt_d  = dwell_q[0];
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            default: begin
                // A write in the same cycle as start takes priority and suppresses the start.
                if (bus.cfg_we) begin
                    cfg_wr = 1'b1;
                end else if (bus.start) begin
                    state_d     = S_RUN;
                    step_d      = '0;
                    cnt_d       = dwell_q[0];
                    fail_step_d = '0;
                    fail_cnt_d  = '0;
                end
            end
        endcase
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_PASS);
    assign bus.fail       = (state_q == S_FAIL);
    assign bus.step       = step_q;
    assign bus.fail_step  = fail_step_q;
    assign bus.fail_count = fail_cnt_q;
endmodule

// File: tb/tb_seq_pattern_checker.sv
// tb/tb_seq_pattern_checker.sv - directed table-driven bench for seq_pattern_checker
module tb_seq_pattern_checker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_pattern_checker_if #(.N_IN(4), .DEPTH(16), .CNT_W(16), .FCNT_W(8)) bus ();

    seq_pattern_checker #(.N_IN(4), .DEPTH(16), .CNT_W(16), .FCNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] din;
        logic       ab;
        logic       we;
        logic       busy;
        logic       done;
        logic       fail;
        logic [3:0] step;
        logic [3:0] fstep;
        logic [7:0] fcnt;
    } cyc_t;

    cyc_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic cyc_t c(input logic [3:0] din, input logic ab, input logic we,
                               input logic busy, input logic done, input logic fail,
                               input logic [3:0] step, input logic [3:0] fstep,
                               input logic [7:0] fcnt);
        cyc_t r;
        r.din = din; r.ab = ab; r.we = we; r.busy = busy; r.done = done; r.fail = fail;
        r.step = step; r.fstep = fstep; r.fcnt = fcnt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string nm, input int k, input logic [18:0] exp);
        logic [18:0] got;
        got = {bus.busy, bus.done, bus.fail, bus.step, bus.fail_step, bus.fail_count};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle T+%0d: got busy/done/fail/step/fstep/fcnt=%b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%0d/%0d/%0d",
                     nm, k, got[18], got[17], got[16], got[15:12], got[11:8], got[7:0],
                     exp[18], exp[17], exp[16], exp[15:12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic chk_val(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic prog(input logic [3:0] a, input logic [3:0] p, input logic [3:0] m,
                        input logic [15:0] d, input logic l);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_pattern = p;
        bus.cfg_mask = m; bus.cfg_dwell = d; bus.cfg_last = l;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    // Record i describes cycle T+1+i: expected outputs, then the din/abort/poke driven in it.
    task automatic run_tbl(input string nm, input logic rof);
        bus.restart_on_fail = rof;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            chk_vec(nm, i + 1, {tbl[i].busy, tbl[i].done, tbl[i].fail,
                                tbl[i].step, tbl[i].fstep, tbl[i].fcnt});
            bus.din   = tbl[i].din;
            bus.abort = tbl[i].ab;
            if (tbl[i].we) begin
                bus.cfg_addr = 4'd2; bus.cfg_pattern = 4'h0; bus.cfg_mask = 4'h0;
                bus.cfg_dwell = 16'd0; bus.cfg_last = 1'b0;
            end
            bus.cfg_we = tbl[i].we;
            tick();
        end
        bus.abort  = 1'b0;
        bus.cfg_we = 1'b0;
        tbl.delete();
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_pattern = 0; bus.cfg_mask = 0;
        bus.cfg_dwell = 0; bus.cfg_last = 0; bus.start = 0; bus.abort = 0;
        bus.restart_on_fail = 0; bus.din = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_vec("reset", 0, 19'd0);

        prog(4'd0, 4'b1010, 4'hF, 16'd2, 1'b0);
        prog(4'd1, 4'b0101, 4'hF, 16'd0, 1'b0);
        prog(4'd2, 4'b1111, 4'h1, 16'd3, 1'b1);

        // Full pass; a write to entry 2 during RUN must not shorten step 2's dwell.
        tbl.push_back(c(4'h0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h5, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'hA, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h5, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 2, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 2, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 2, 0, 0));
        tbl.push_back(c(4'h1, 0, 0, 1, 0, 0, 2, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 0, 1, 0, 2, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 0, 1, 0, 2, 0, 0));
        run_tbl("pass", 1'b0);

        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'hA, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h4, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 0, 0, 1, 1, 1, 1));
        tbl.push_back(c(4'h0, 0, 0, 0, 0, 1, 1, 1, 1));
        run_tbl("stop_on_fail", 1'b0);

        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'hA, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h4, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(c(4'hA, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(c(4'h5, 0, 0, 1, 0, 0, 1, 1, 1));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 2, 1, 1));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 2, 1, 1));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 2, 1, 1));
        tbl.push_back(c(4'h1, 0, 0, 1, 0, 0, 2, 1, 1));
        tbl.push_back(c(4'h0, 0, 0, 0, 1, 0, 2, 1, 1));
        run_tbl("restart_on_fail", 1'b1);

        // Abort on a mismatching sample cycle: IDLE, nothing recorded.
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("abort", 1'b0);

        // start together with cfg_we in IDLE: only the write (step 2 dwell 1) happens.
        bus.cfg_addr = 4'd2; bus.cfg_pattern = 4'hF; bus.cfg_mask = 4'h1;
        bus.cfg_dwell = 16'd1; bus.cfg_last = 1'b1;
        bus.cfg_we = 1'b1; bus.start = 1'b1;
        tick();
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        chk_vec("start_with_we", 1, 19'd0);
        tick();
        chk_vec("start_with_we", 2, 19'd0);

        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h5, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'hA, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(c(4'h5, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 2, 0, 0));
        tbl.push_back(c(4'h1, 0, 0, 1, 0, 0, 2, 0, 0));
        tbl.push_back(c(4'h0, 0, 0, 0, 1, 0, 2, 0, 0));
        run_tbl("new_dwell", 1'b0);

        // 300 mismatches at step 0 (one every 3 cycles) with restart: count saturates.
        bus.restart_on_fail = 1'b1;
        bus.din = 4'h0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (904) tick();
        chk_val("sat_fail_count", int'(bus.fail_count), 255);
        chk_val("sat_busy", int'(bus.busy), 1);
        chk_val("sat_fail_step", int'(bus.fail_step), 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_val("sat_abort_busy", int'(bus.busy), 0);
        chk_val("sat_abort_hold_count", int'(bus.fail_count), 255);

        // Reset mid-run clears state and entries.
        bus.restart_on_fail = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_vec("mid_reset", 0, 19'd0);

        // Cleared entries: mask 0, dwell 0, last 0 -> implicit end after 16 samples.
        for (int i = 0; i < 16; i++) begin
            tbl.push_back(c(4'h0, 0, 0, 1, 0, 0, 4'(i), 0, 0));
        end
        tbl.push_back(c(4'h0, 0, 0, 0, 1, 0, 15, 0, 0));
        run_tbl("implicit_end", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
